// File: rtl/left_shift_pipe.sv
// left_shift_pipe: request queue feeding a registered left shifter with shifted-out-ones flag
module left_shift_pipe #(
    parameter int DATA_WIDTH  = 8,
    parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH),
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        IN_VALID,
    output logic                        IN_READY,
    input  logic [DATA_WIDTH-1:0]       IDATA,
    input  logic [SHIFT_WIDTH-1:0]      N_SHIFT,
    output logic                        OUT_VALID,
    input  logic                        OUT_READY,
    output logic [DATA_WIDTH-1:0]       ODATA,
    output logic                        OUT_LOST,
    output logic [$clog2(FIFO_DEPTH):0] COUNT
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0]  r_mem_data  [FIFO_DEPTH];
    logic [SHIFT_WIDTH-1:0] r_mem_shift [FIFO_DEPTH];
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [PW:0]            r_count;
    logic                   r_out_valid;
    logic                   r_out_lost;
    logic [DATA_WIDTH-1:0]  r_out_data;

    logic                   w_push;
    logic                   w_pop;
    logic [DATA_WIDTH-1:0]  w_head_data;
    logic [SHIFT_WIDTH-1:0] w_head_shift;
    logic [DATA_WIDTH-1:0]  w_shifted;
    logic [DATA_WIDTH-1:0]  w_lost_mask;

    assign IN_READY     = r_count != FULL;
    assign w_push       = IN_VALID & IN_READY;
    assign w_pop        = (r_count != '0) & (~r_out_valid | OUT_READY);
    assign w_head_data  = r_mem_data[r_rd_ptr];
    assign w_head_shift = r_mem_shift[r_rd_ptr];
    assign w_shifted    = w_head_data << w_head_shift;
    assign w_lost_mask  = ~({DATA_WIDTH{1'b1}} >> w_head_shift);

    // queue storage carries no reset; only pointers and count define validity
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr]  <= IDATA;
            r_mem_shift[r_wr_ptr] <= N_SHIFT;
        end
    end

    // pointers wrap naturally at the power-of-two depth; count tracks push minus pop
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_push ? r_wr_ptr + PW'(1) : r_wr_ptr;
            r_rd_ptr <= w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;
            r_count  <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

    // output register loads the shifted head on pop, empties when consumed with nothing queued
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_lost  <= 1'b0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_shifted;
            r_out_lost  <= |(w_head_data & w_lost_mask);
        end else if (OUT_READY) begin
            r_out_valid <= 1'b0;
        end
    end

    assign OUT_VALID = r_out_valid;
    assign ODATA     = r_out_data;
    assign OUT_LOST  = r_out_lost;
    assign COUNT     = r_count;
endmodule

// File: tb/tb_left_shift_pipe.sv
// tb_left_shift_pipe: directed and randomized checks of left_shift_pipe against a transaction model
module tb_left_shift_pipe;
    localparam int DW = 8;
    localparam int SW = 3;
    localparam int FD = 4;
    localparam int CW = 3;

    logic          clk = 0;
    logic          rst_n = 1;
    logic          in_valid = 0;
    logic          out_ready = 0;
    logic [DW-1:0] idata = 0;
    logic [SW-1:0] n_shift = 0;
    logic          in_ready;
    logic          out_valid;
    logic          out_lost;
    logic [DW-1:0] odata;
    logic [CW-1:0] count;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    left_shift_pipe #(.DATA_WIDTH(DW), .SHIFT_WIDTH(SW), .FIFO_DEPTH(FD)) dut (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
        .IDATA(idata), .N_SHIFT(n_shift), .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .ODATA(odata), .OUT_LOST(out_lost), .COUNT(count)
    );

    // result as {lost, data}: multiply by 2^n, keep low DW bits, lost if anything overflowed
    function automatic logic [DW:0] ref_shift(input int d, input int n);
        int p;
        p = d * (2 ** n);
        return {(p >= (1 << DW)) ? 1'b1 : 1'b0, DW'(p % (1 << DW))};
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        #1 rst_n = 0;
        #1;
        total += 5;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst0_valid: got %b want 0", out_valid); end
        if (count !== 0) begin bad++; $display("FAIL rst0_count: got %0d want 0", count); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst0_ready: got %b want 1", in_ready); end
        if (odata !== 8'h00) begin bad++; $display("FAIL rst0_odata: got %h want 00", odata); end
        if (out_lost !== 1'b0) begin bad++; $display("FAIL rst0_lost: got %b want 0", out_lost); end
        @(negedge clk);
        rst_n = 1;
        in_valid = 1; idata = 8'hFF; n_shift = 1; out_ready = 0;
        tick;
        in_valid = 0;
        tick;
        total += 2;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL pre_rst_valid: got %b want 1", out_valid); end
        if (odata !== 8'hFE) begin bad++; $display("FAIL pre_rst_odata: got %h want fe", odata); end
        #2 rst_n = 0;
        #1;
        total += 4;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        if (count !== 0) begin bad++; $display("FAIL rst_count: got %0d want 0", count); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", in_ready); end
        if (odata !== 8'h00) begin bad++; $display("FAIL rst_odata: got %h want 00", odata); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_single;
        out_ready = 1; in_valid = 1; idata = 8'h96; n_shift = 3;
        tick;
        in_valid = 0;
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early: got %b want 0", out_valid); end
        if (count !== 1) begin bad++; $display("FAIL single_count: got %0d want 1", count); end
        tick;
        total += 3;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", out_valid); end
        if (odata !== 8'hB0) begin bad++; $display("FAIL single_odata: got %h want b0", odata); end
        if (out_lost !== 1'b1) begin bad++; $display("FAIL single_lost: got %b want 1", out_lost); end
        tick;
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain: got %b want 0", out_valid); end
        if (count !== 0) begin bad++; $display("FAIL single_empty: got %0d want 0", count); end
    endtask

    task automatic test_zero_shift;
        logic [DW-1:0] din  [2] = '{8'h5A, 8'h01};
        logic [SW-1:0] sh   [2] = '{3'd0, 3'd7};
        logic [DW-1:0] dout [2] = '{8'h5A, 8'h80};
        out_ready = 1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; idata = din[i]; n_shift = sh[i];
            tick;
            in_valid = 0;
            tick;
            total += 3;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL edge_valid[%0d]: got %b want 1", i, out_valid); end
            if (odata !== dout[i]) begin bad++; $display("FAIL edge_odata[%0d]: got %h want %h", i, odata, dout[i]); end
            if (out_lost !== 1'b0) begin bad++; $display("FAIL edge_lost[%0d]: got %b want 0", i, out_lost); end
            tick;
        end
    endtask

    task automatic test_backpressure;
        logic [DW:0] exp_res [6];
        logic [DW:0] held;
        out_ready = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1;
            idata = DW'(i * 40 + int'($urandom_range(1, 30)));
            n_shift = SW'($urandom_range(0, 7));
            exp_res[i] = ref_shift(idata, n_shift);
            total++;
            if (in_ready !== (i < 5)) begin bad++; $display("FAIL bp_ready[%0d]: got %b want %b", i, in_ready, i < 5); end
            tick;
        end
        in_valid = 0;
        total += 4;
        if (count !== 4) begin bad++; $display("FAIL bp_count: got %0d want 4", count); end
        if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
        if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", out_valid); end
        if ({out_lost, odata} !== exp_res[0]) begin bad++; $display("FAIL bp_head: got %h want %h", {out_lost, odata}, exp_res[0]); end
        held = {out_lost, odata};
        for (int s = 0; s < 3; s++) begin
            tick;
            total++;
            if ({out_lost, odata} !== held) begin bad++; $display("FAIL bp_stable[%0d]: got %h want %h", s, {out_lost, odata}, held); end
        end
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            total += 2;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid); end
            if ({out_lost, odata} !== exp_res[i]) begin bad++; $display("FAIL bp_order[%0d]: got %h want %h", i, {out_lost, odata}, exp_res[i]); end
            tick;
        end
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_end_valid: got %b want 0", out_valid); end
        if (count !== 0) begin bad++; $display("FAIL bp_end_count: got %0d want 0", count); end
    endtask

    task automatic test_full_pop;
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; idata = DW'($urandom); n_shift = SW'($urandom);
            tick;
        end
        total += 3;
        if (count !== 4) begin bad++; $display("FAIL fp_count: got %0d want 4", count); end
        if (out_valid !== 1'b1) begin bad++; $display("FAIL fp_valid: got %b want 1", out_valid); end
        if (in_ready !== 1'b0) begin bad++; $display("FAIL fp_ready: got %b want 0", in_ready); end
        in_valid = 1; idata = 8'hC3; out_ready = 1;
        tick;
        in_valid = 0;
        total += 3;
        if (count !== 3) begin bad++; $display("FAIL fp_count_after: got %0d want 3", count); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL fp_ready_after: got %b want 1", in_ready); end
        if (out_valid !== 1'b1) begin bad++; $display("FAIL fp_valid_after: got %b want 1", out_valid); end
        for (int i = 0; i < 8 && out_valid; i++) tick;
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL fp_drain: got %b want 0", out_valid); end
        if (count !== 0) begin bad++; $display("FAIL fp_drain_count: got %0d want 0", count); end
    endtask

    task automatic test_random;
        logic [DW+SW-1:0] q [$];
        logic [DW+SW-1:0] it;
        logic             m_ov;
        logic [DW:0]      m_res;
        bit               push;
        bit               pop;
        m_ov = 0;
        m_res = '0;
        for (int c = 0; c < 400; c++) begin
            total += 3;
            if (in_ready !== (q.size() < FD)) begin bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, in_ready, q.size() < FD); end
            if (count !== CW'(q.size())) begin bad++; $display("FAIL rnd_count[%0d]: got %0d want %0d", c, count, q.size()); end
            if (out_valid !== m_ov) begin bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, out_valid, m_ov); end
            if (m_ov) begin
                total++;
                if ({out_lost, odata} !== m_res) begin bad++; $display("FAIL rnd_result[%0d]: got %h want %h", c, {out_lost, odata}, m_res); end
            end
            in_valid = $urandom_range(0, 3) != 0;
            idata = DW'($urandom);
            n_shift = SW'($urandom);
            out_ready = $urandom_range(0, 2) != 0;
            push = in_valid && q.size() < FD;
            pop = q.size() > 0 && (!m_ov || out_ready);
            if (pop) begin
                it = q.pop_front();
                m_res = ref_shift(it[DW+SW-1:SW], it[SW-1:0]);
                m_ov = 1;
            end else if (out_ready) begin
                m_ov = 0;
            end
            if (push) q.push_back({idata, n_shift});
            tick;
        end
        in_valid = 0;
        out_ready = 1;
        for (int i = 0; i < 8; i++) tick;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rnd_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid;
        logic [DW:0] exp_res;
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; idata = DW'($urandom); n_shift = SW'($urandom);
            tick;
        end
        in_valid = 0;
        total += 2;
        if (count !== 3) begin bad++; $display("FAIL mid_count: got %0d want 3", count); end
        if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_valid: got %b want 1", out_valid); end
        #2 rst_n = 0;
        #1;
        total += 5;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
        if (count !== 0) begin bad++; $display("FAIL mid_rst_count: got %0d want 0", count); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready: got %b want 1", in_ready); end
        if (odata !== 8'h00) begin bad++; $display("FAIL mid_rst_odata: got %h want 00", odata); end
        if (out_lost !== 1'b0) begin bad++; $display("FAIL mid_rst_lost: got %b want 0", out_lost); end
        @(negedge clk);
        rst_n = 1;
        in_valid = 1; idata = 8'h3C; n_shift = 2; out_ready = 1;
        exp_res = ref_shift(idata, n_shift);
        tick;
        in_valid = 0;
        tick;
        total += 2;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_after_valid: got %b want 1", out_valid); end
        if ({out_lost, odata} !== exp_res) begin bad++; $display("FAIL mid_after_result: got %h want %h", {out_lost, odata}, exp_res); end
        tick;
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_alone_valid: got %b want 0", out_valid); end
        if (count !== 0) begin bad++; $display("FAIL mid_alone_count: got %0d want 0", count); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_zero_shift;
        test_backpressure;
        test_full_pop;
        test_random;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
